// File: rtl/mem_wb_pkg.sv
// Shared constants and types for the memory/writeback sequencer.
package mem_wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned BE_W   = 4;

  localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
  localparam logic [OP_W-1:0] OP_LBU = 6'b100100;
  localparam logic [OP_W-1:0] OP_LHU = 6'b100101;
  localparam logic [OP_W-1:0] OP_LL  = 6'b110000;
  localparam logic [OP_W-1:0] OP_SW  = 6'b101011;
  localparam logic [OP_W-1:0] OP_SB  = 6'b101000;
  localparam logic [OP_W-1:0] OP_SH  = 6'b101001;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_CONFLICT = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Fields of the accepted instruction still needed after the memory access
  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic             load;
    logic [REG_W-1:0] rd;
    logic [1:0]       lane;
  } instr_t;

endpackage

// File: rtl/mem_wb_sequencer_if.sv
// Decoder bundle, data-memory bus, register-file write port and error flags.
interface mem_wb_sequencer_if;
  import mem_wb_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   opCode;
  logic              regWr;
  logic              memRead;
  logic              memWr;
  logic [REG_W-1:0]  rd;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;

  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic              err;
  logic [1:0]        err_code;

  modport master (
    input  in_valid, opCode, regWr, memRead, memWr, rd, alu_result, store_data,
    input  mem_ack, mem_rdata,
    output in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output rf_we, rf_waddr, rf_wdata, err, err_code
  );

  modport slave (
    output in_valid, opCode, regWr, memRead, memWr, rd, alu_result, store_data,
    output mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  rf_we, rf_waddr, rf_wdata, err, err_code
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication, load extraction, alignment check.
module mem_lane_align
  import mem_wb_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] sdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_al,
  output logic              misaligned
);

  always_comb begin
    be         = '1;
    wdata      = sdata;
    rdata_al   = rdata;
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_LL, OP_SW: misaligned = (lane != 2'b00);
      OP_LHU: begin
        misaligned = lane[0];
        rdata_al   = {16'h0000, (lane[1] ? rdata[31:16] : rdata[15:0])};
      end
      OP_LBU: rdata_al = {24'h000000, rdata[{lane, 3'b000} +: 8]};
      OP_SH: begin
        misaligned = lane[0];
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{sdata[15:0]}};
      end
      OP_SB: begin
        be    = BE_W'(4'b0001 << lane);
        wdata = {4{sdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_sequencer.sv
// Executes one decoded instruction at a time: memory req/ack, register writeback, errors.
module mem_wb_sequencer
  import mem_wb_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5
) (
  input logic               clk,
  input logic               rst,
  mem_wb_sequencer_if.master bus
);

  state_t            state, state_n;
  instr_t            cap_q, cap_n;
  logic [TO_W-1:0]   to_cnt, to_n;
  logic              in_ready_q, in_ready_n;
  logic              mem_req_q, mem_req_n, mem_we_q, mem_we_n;
  logic [BE_W-1:0]   mem_be_q, mem_be_n;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_n, mem_wdata_q, mem_wdata_n;
  logic              rf_we_q, rf_we_n;
  logic [REG_W-1:0]  rf_waddr_q, rf_waddr_n;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_n;
  logic              err_q, err_n;
  logic [1:0]        err_code_q, err_code_n;

  logic              idle;
  logic [BE_W-1:0]   al_be;
  logic [DATA_W-1:0] al_wdata, al_rdata;
  logic              al_mis;

  // The aligner sees live inputs while idle and the captured instruction during MEM
  assign idle = (state == ST_IDLE);

  mem_lane_align u_align (
    .op         (idle ? bus.opCode : cap_q.op),
    .lane       (idle ? bus.alu_result[1:0] : cap_q.lane),
    .sdata      (bus.store_data),
    .rdata      (bus.mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .rdata_al   (al_rdata),
    .misaligned (al_mis)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cap_q       <= '0;
      to_cnt      <= '0;
      in_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state       <= state_n;
      cap_q       <= cap_n;
      to_cnt      <= to_n;
      in_ready_q  <= in_ready_n;
      mem_req_q   <= mem_req_n;
      mem_we_q    <= mem_we_n;
      mem_be_q    <= mem_be_n;
      mem_addr_q  <= mem_addr_n;
      mem_wdata_q <= mem_wdata_n;
      rf_we_q     <= rf_we_n;
      rf_waddr_q  <= rf_waddr_n;
      rf_wdata_q  <= rf_wdata_n;
      err_q       <= err_n;
      err_code_q  <= err_code_n;
    end
  end

  // Next state and next registered outputs; bus fields hold unless updated
  always_comb begin
    state_n     = state;
    cap_n       = cap_q;
    to_n        = to_cnt;
    mem_req_n   = mem_req_q;
    mem_we_n    = mem_we_q;
    mem_be_n    = mem_be_q;
    mem_addr_n  = mem_addr_q;
    mem_wdata_n = mem_wdata_q;
    rf_we_n     = 1'b0;
    rf_waddr_n  = rf_waddr_q;
    rf_wdata_n  = rf_wdata_q;
    err_n       = 1'b0;
    err_code_n  = err_code_q;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          cap_n = '{op: bus.opCode, load: bus.memRead, rd: bus.rd,
                    lane: bus.alu_result[1:0]};
          if (bus.memRead && bus.memWr) begin
            state_n    = ST_ERR;
            err_n      = 1'b1;
            err_code_n = ERR_CONFLICT;
          end else if (bus.memRead || bus.memWr) begin
            if (al_mis) begin
              state_n    = ST_ERR;
              err_n      = 1'b1;
              err_code_n = ERR_MISALIGN;
            end else begin
              state_n     = ST_MEM;
              to_n        = '0;
              mem_req_n   = 1'b1;
              mem_we_n    = bus.memWr;
              mem_be_n    = al_be;
              mem_addr_n  = {bus.alu_result[DATA_W-1:2], 2'b00};
              mem_wdata_n = al_wdata;
            end
          end else if (bus.regWr) begin
            state_n    = ST_WB;
            rf_we_n    = (bus.rd != '0);
            rf_waddr_n = bus.rd;
            rf_wdata_n = bus.alu_result;
          end
        end
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          mem_req_n = 1'b0;
          if (cap_q.load) begin
            state_n    = ST_WB;
            rf_we_n    = (cap_q.rd != '0);
            rf_waddr_n = cap_q.rd;
            rf_wdata_n = al_rdata;
          end else begin
            state_n = ST_IDLE;
          end
        end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
          mem_req_n  = 1'b0;
          state_n    = ST_ERR;
          err_n      = 1'b1;
          err_code_n = ERR_TIMEOUT;
        end else begin
          to_n = TO_W'(to_cnt + 1'b1);
        end
      end
      ST_WB:   state_n = ST_IDLE;
      ST_ERR:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    in_ready_n = (state_n == ST_IDLE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_mem_wb_sequencer.sv
// Directed vector bench for mem_wb_sequencer, plus timeout and reset sequences.
module tb_mem_wb_sequencer;

  localparam int unsigned ACK_TIMEOUT = 16;
  localparam int NV = 19;

  typedef enum int {K_NOP, K_WB, K_LOAD, K_STORE, K_ERR} kind_t;

  typedef struct {
    logic [5:0]  op;
    logic        rw, mr, mw;
    logic [4:0]  rd;
    logic [31:0] alu, sdata, rdata;
    int          dly;
    kind_t       kind;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [1:0]  code;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs [NV];

  mem_wb_sequencer_if ifc ();

  mem_wb_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic rw, input logic mr,
                              input logic mw, input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] sdata, input logic [31:0] rdata,
                              input int dly, input kind_t kind, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic rf_we, input logic [31:0] rf_wdata,
                              input logic [1:0] code);
    vec_t v;
    v.op = op; v.rw = rw; v.mr = mr; v.mw = mw; v.rd = rd; v.alu = alu;
    v.sdata = sdata; v.rdata = rdata; v.dly = dly; v.kind = kind; v.be = be;
    v.addr = addr; v.wdata = wdata; v.rf_we = rf_we; v.rf_wdata = rf_wdata; v.code = code;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ifc.in_ready), 32'd1);
    chk({tag, "_req"},   32'(ifc.mem_req),  32'd0);
    chk({tag, "_rfwe"},  32'(ifc.rf_we),    32'd0);
    chk({tag, "_err"},   32'(ifc.err),      32'd0);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    chk({t, "_ready_pre"}, 32'(ifc.in_ready), 32'd1);
    ifc.in_valid = 1'b1; ifc.opCode = v.op; ifc.regWr = v.rw; ifc.memRead = v.mr;
    ifc.memWr = v.mw; ifc.rd = v.rd; ifc.alu_result = v.alu; ifc.store_data = v.sdata;
    step();
    ifc.in_valid = 1'b0; ifc.regWr = 1'b0; ifc.memRead = 1'b0; ifc.memWr = 1'b0;
    ifc.store_data = 32'h0;
    case (v.kind)
      K_NOP: check_idle_outputs({t, "_nop"});
      K_WB: begin
        chk({t, "_ready_busy"}, 32'(ifc.in_ready), 32'd0);
        chk({t, "_rfwe"}, 32'(ifc.rf_we), 32'(v.rf_we));
        if (v.rf_we) begin
          chk({t, "_waddr"}, 32'(ifc.rf_waddr), 32'(v.rd));
          chk({t, "_wdata"}, ifc.rf_wdata, v.rf_wdata);
        end
        step();
        check_idle_outputs({t, "_after"});
      end
      K_ERR: begin
        chk({t, "_err"}, 32'(ifc.err), 32'd1);
        chk({t, "_code"}, 32'(ifc.err_code), 32'(v.code));
        chk({t, "_noreq"}, 32'(ifc.mem_req), 32'd0);
        chk({t, "_norf"}, 32'(ifc.rf_we), 32'd0);
        step();
        check_idle_outputs({t, "_after"});
        chk({t, "_code_hold"}, 32'(ifc.err_code), 32'(v.code));
      end
      default: begin
        chk({t, "_req"},  32'(ifc.mem_req), 32'd1);
        chk({t, "_we"},   32'(ifc.mem_we), 32'(v.kind == K_STORE));
        chk({t, "_be"},   32'(ifc.mem_be), 32'(v.be));
        chk({t, "_addr"}, ifc.mem_addr, v.addr);
        if (v.kind == K_STORE) chk({t, "_mwdata"}, ifc.mem_wdata, v.wdata);
        chk({t, "_ready_busy"}, 32'(ifc.in_ready), 32'd0);
        for (int k = 0; k < v.dly; k++) begin
          step();
          chk({t, "_req_hold"}, 32'(ifc.mem_req), 32'd1);
          chk({t, "_addr_hold"}, ifc.mem_addr, v.addr);
        end
        ifc.mem_ack = 1'b1; ifc.mem_rdata = v.rdata;
        step();
        ifc.mem_ack = 1'b0; ifc.mem_rdata = 32'h0;
        chk({t, "_req_drop"}, 32'(ifc.mem_req), 32'd0);
        if (v.kind == K_STORE) begin
          check_idle_outputs({t, "_st_done"});
        end else begin
          chk({t, "_rfwe"}, 32'(ifc.rf_we), 32'(v.rf_we));
          if (v.rf_we) begin
            chk({t, "_waddr"}, 32'(ifc.rf_waddr), 32'(v.rd));
            chk({t, "_wdata"}, ifc.rf_wdata, v.rf_wdata);
          end
          chk({t, "_ready_wb"}, 32'(ifc.in_ready), 32'd0);
          step();
          check_idle_outputs({t, "_ld_done"});
        end
      end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(ifc.in_ready), 32'd1);
    chk({tag, "_req"},   32'(ifc.mem_req), 32'd0);
    chk({tag, "_we"},    32'(ifc.mem_we), 32'd0);
    chk({tag, "_be"},    32'(ifc.mem_be), 32'd0);
    chk({tag, "_addr"},  ifc.mem_addr, 32'd0);
    chk({tag, "_wdata"}, ifc.mem_wdata, 32'd0);
    chk({tag, "_rfwe"},  32'(ifc.rf_we), 32'd0);
    chk({tag, "_waddr"}, 32'(ifc.rf_waddr), 32'd0);
    chk({tag, "_rfdata"}, ifc.rf_wdata, 32'd0);
    chk({tag, "_err"},   32'(ifc.err), 32'd0);
    chk({tag, "_code"},  32'(ifc.err_code), 32'd0);
  endtask

  initial begin
    int cnt;
    ifc.in_valid = 1'b0; ifc.opCode = '0; ifc.regWr = 1'b0; ifc.memRead = 1'b0;
    ifc.memWr = 1'b0; ifc.rd = '0; ifc.alu_result = '0; ifc.store_data = '0;
    ifc.mem_ack = 1'b0; ifc.mem_rdata = '0;

    //          op         rw mr mw rd     alu            sdata          rdata          dly kind     be       addr           wdata          rfwe rf_wdata       code
    vecs[0]  = mk(6'b001000, 1, 0, 0, 5'd8,  32'h0000_0005, 32'h0,         32'h0,         0, K_WB,    4'h0,   32'h0,         32'h0,         1, 32'h0000_0005, 2'b00);
    vecs[1]  = mk(6'b100100, 1, 1, 0, 5'd9,  32'h0000_0103, 32'h0,         32'hAABB_CCDD, 3, K_LOAD,  4'hF,   32'h0000_0100, 32'h0,         1, 32'h0000_00AA, 2'b00);
    vecs[2]  = mk(6'b101001, 0, 0, 1, 5'd0,  32'h0000_0202, 32'h1234_5678, 32'h0,         2, K_STORE, 4'hC,   32'h0000_0200, 32'h5678_5678, 0, 32'h0,         2'b00);
    vecs[3]  = mk(6'b100011, 1, 1, 0, 5'd10, 32'h0000_0101, 32'h0,         32'h0,         0, K_ERR,   4'h0,   32'h0,         32'h0,         0, 32'h0,         2'b01);
    vecs[4]  = mk(6'b001000, 1, 0, 0, 5'd0,  32'h0000_0077, 32'h0,         32'h0,         0, K_WB,    4'h0,   32'h0,         32'h0,         0, 32'h0,         2'b00);
    vecs[5]  = mk(6'b101000, 0, 0, 1, 5'd0,  32'h0000_0301, 32'h0000_00EF, 32'h0,         0, K_STORE, 4'h2,   32'h0000_0300, 32'hEFEF_EFEF, 0, 32'h0,         2'b00);
    vecs[6]  = mk(6'b100101, 1, 1, 0, 5'd11, 32'h0000_0402, 32'h0,         32'h1122_3344, 1, K_LOAD,  4'hF,   32'h0000_0400, 32'h0,         1, 32'h0000_1122, 2'b00);
    vecs[7]  = mk(6'b100011, 1, 1, 0, 5'd31, 32'h0000_0500, 32'h0,         32'hDEAD_BEEF, 5, K_LOAD,  4'hF,   32'h0000_0500, 32'h0,         1, 32'hDEAD_BEEF, 2'b00);
    vecs[8]  = mk(6'b101011, 0, 0, 1, 5'd0,  32'h0000_0600, 32'hCAFE_F00D, 32'h0,         1, K_STORE, 4'hF,   32'h0000_0600, 32'hCAFE_F00D, 0, 32'h0,         2'b00);
    vecs[9]  = mk(6'b100101, 1, 1, 0, 5'd11, 32'h0000_0403, 32'h0,         32'h0,         0, K_ERR,   4'h0,   32'h0,         32'h0,         0, 32'h0,         2'b01);
    vecs[10] = mk(6'b100011, 1, 1, 1, 5'd4,  32'h0000_0000, 32'h0,         32'h0,         0, K_ERR,   4'h0,   32'h0,         32'h0,         0, 32'h0,         2'b10);
    vecs[11] = mk(6'b000100, 0, 0, 0, 5'd0,  32'h0000_0010, 32'h0,         32'h0,         0, K_NOP,   4'h0,   32'h0,         32'h0,         0, 32'h0,         2'b00);
    vecs[12] = mk(6'b101001, 0, 0, 1, 5'd0,  32'h0000_0200, 32'h0000_BEEF, 32'h0,         0, K_STORE, 4'h3,   32'h0000_0200, 32'hBEEF_BEEF, 0, 32'h0,         2'b00);
    vecs[13] = mk(6'b110000, 1, 1, 0, 5'd12, 32'h0000_0704, 32'h0,         32'h0123_4567, 2, K_LOAD,  4'hF,   32'h0000_0704, 32'h0,         1, 32'h0123_4567, 2'b00);
    vecs[14] = mk(6'b100100, 1, 1, 0, 5'd13, 32'h0000_0101, 32'h0,         32'hAABB_CCDD, 0, K_LOAD,  4'hF,   32'h0000_0100, 32'h0,         1, 32'h0000_00CC, 2'b00);
    vecs[15] = mk(6'b101000, 0, 0, 1, 5'd0,  32'h0000_0003, 32'h0000_005A, 32'h0,         1, K_STORE, 4'h8,   32'h0000_0000, 32'h5A5A_5A5A, 0, 32'h0,         2'b00);
    vecs[16] = mk(6'b100100, 1, 1, 0, 5'd0,  32'h0000_0100, 32'h0,         32'hAABB_CCDD, 1, K_LOAD,  4'hF,   32'h0000_0100, 32'h0,         0, 32'h0,         2'b00);
    vecs[17] = mk(6'b101011, 0, 0, 1, 5'd0,  32'h0000_0602, 32'h1111_1111, 32'h0,         0, K_ERR,   4'h0,   32'h0,         32'h0,         0, 32'h0,         2'b01);
    vecs[18] = mk(6'b101001, 0, 0, 1, 5'd0,  32'h0000_0201, 32'h2222_2222, 32'h0,         0, K_ERR,   4'h0,   32'h0,         32'h0,         0, 32'h0,         2'b01);

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    step();
    check_all_zero("post_reset");

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Stray ack while idle must not trigger anything
    ifc.mem_ack = 1'b1; ifc.mem_rdata = 32'h5555_5555;
    step();
    ifc.mem_ack = 1'b0;
    step();
    check_idle_outputs("stray_ack");

    // Timeout: load with no ack
    ifc.in_valid = 1'b1; ifc.opCode = 6'b100011; ifc.regWr = 1'b1; ifc.memRead = 1'b1;
    ifc.rd = 5'd7; ifc.alu_result = 32'h0000_0800;
    step();
    ifc.in_valid = 1'b0; ifc.regWr = 1'b0; ifc.memRead = 1'b0;
    cnt = 0;
    while (ifc.mem_req && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to_req_cycles", 32'(cnt), 32'(ACK_TIMEOUT));
    chk("to_err", 32'(ifc.err), 32'd1);
    chk("to_code", 32'(ifc.err_code), 32'b11);
    chk("to_norf", 32'(ifc.rf_we), 32'd0);
    step();
    ifc.mem_ack = 1'b1; ifc.mem_rdata = 32'h9999_9999;
    step();
    ifc.mem_ack = 1'b0;
    check_idle_outputs("to_late_ack");
    step();
    check_idle_outputs("to_late_ack2");

    // Reset in the middle of a load
    ifc.in_valid = 1'b1; ifc.opCode = 6'b100011; ifc.regWr = 1'b1; ifc.memRead = 1'b1;
    ifc.rd = 5'd6; ifc.alu_result = 32'h0000_0900;
    step();
    ifc.in_valid = 1'b0; ifc.regWr = 1'b0; ifc.memRead = 1'b0;
    ifc.rd = '0; ifc.alu_result = '0; ifc.opCode = '0;
    step();
    chk("rst_req_before", 32'(ifc.mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_async", 32'(ifc.mem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ifc.mem_ack = 1'b1; ifc.mem_rdata = 32'h7777_7777;
    step();
    ifc.mem_ack = 1'b0;
    step();
    check_all_zero("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
